mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Multi-cycle multiply/divide responder for the ALU's MULT/DIV requests.
//  Accepts a start pulse with operands and an op code.
//  Iterates one bit per cycle and writes the 64-bit product, or the quotient and remainder, into HI/LO.
//  Signals completion with a one-cycle done pulse.
//  The ALU reads HI/LO (MFHI/MFLO) from this block once it is idle.
// PARAMETERS
//  WIDTH  32  operand width; iteration count = WIDTH; HI/LO each WIDTH bits
// PORTS
//  clkACC  in   1      clock, rising edge
//  reset   in   1      asynchronous, active-low reset
//  start   in   1      request; sampled only when busy=0
//  op      in   2      00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//  A       in   WIDTH  multiplicand / dividend
//  B       in   WIDTH  multiplier / divisor
//  busy    out  1      1 in CALC and FIX states
//  done    out  1      one-cycle pulse in DONE state; HI/LO valid from this cycle
//  hi      out  WIDTH  MULT: product[63:32]; DIV: remainder
//  lo      out  WIDTH  MULT: product[31:0];  DIV: quotient
//  div0    out  1      only when MDU_DIV0_EN is defined; see CONFIGURATION
// BEHAVIOUR
//  - Reset (reset=0, async):
//    - state=IDLE; busy=0, done=0, hi=0, lo=0, div0=0
//    - any in-flight operation is discarded
//  - FSM: IDLE -> CALC (start=1) -> FIX (after WIDTH CALC cycles) -> DONE (1 cycle) -> IDLE
//    - DONE with start=1 goes straight to CALC (back-to-back issue)
//  - Start edge E0: latch op, capture |A| and |B| for signed ops (raw for unsigned), record result signs.
//  - CALC, edges E1..E32:
//    - MULT: shift-add, one multiplier bit per cycle, 64-bit unsigned accumulator.
//    - DIV: restoring division, one quotient bit per cycle, WIDTH+1-bit partial remainder.
//  - FIX, edge E33:
//    - MULT: negate the 64-bit product if the operand signs differ.
//    - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
//    - Write hi/lo.
//  - DONE, edge E34: done=1 and busy=0 for exactly one cycle. Latency = 34 cycles, start edge to done.
//  - start while busy=1 is ignored; operands and op are not re-sampled.
//  - hi/lo hold their values in IDLE and are updated only at FIX, never mid-operation.
//  - Arithmetic is mod 2^WIDTH per half.
//    - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. No trap, no flag.
//  - Unsigned operands of 0x80000000 or above are never sign-adjusted.
// CONFIGURATION
//  - MDU_DIV0_EN defined:
//    - DIV/DIVU with B=0 is detected at the start edge and skips CALC (IDLE -> FIX -> DONE; done 2 cycles after start).
//    - Result: lo=0xFFFFFFFF, hi=A (raw operand).
//    - div0=1 from FIX until the next accepted start or reset.
//  - MDU_DIV0_EN undefined:
//    - No div0 port. B=0 runs the full 32 cycles.
//    - The magnitude result is q=0xFFFFFFFF, r=|A|, then normal sign fix.
//      - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
//      - DIV -5/0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFB.
// TESTING
//  - MULT A=0xFFFFFFFD (-3), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 34 cycles after start; busy=1 for cycles 1..33.
//  - MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  - DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    - DIVU A=100, B=7 -> lo=14, hi=2.
//    - DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
//  - DIVU 100/7 in flight; at cycle 10 assert start with MULTU 3*3 -> ignored, result still 14/2.
//    - Then start in the DONE cycle -> accepted; 9/0 after 34 more cycles.
//  - Reset pulse at cycle 15 of DIV 100/7 -> busy=0, done=0, hi=lo=0 immediately.
//    - No done afterwards.
//    - A new start runs normally.
//  - DIVU A=5, B=0:
//    - with MDU_DIV0_EN -> done 2 cycles after start, lo=0xFFFFFFFF, hi=5, div0=1.
//    - without -> done at 34, same hi/lo.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: one bit per cycle, results in HI/LO, one-cycle done pulse.
// Optional macro MDU_DIV0_EN: early divide-by-zero handling with a div0 flag output.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clkACC,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MDU_DIV0_EN
  ,
  output logic             div0
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt;
  logic               op_div, q_neg, r_neg;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   lower, opb;
  logic               accept, div0_hit, is_signed;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;
`ifdef MDU_DIV0_EN
  logic               zdiv;
`endif

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v, input logic sgn);
    return (sgn && v < 0) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign is_signed = ~op[0];
  assign accept    = start && (state_q == S_IDLE || state_q == S_DONE);
  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);

`ifdef MDU_DIV0_EN
  assign div0_hit = op[1] && (B == '0);
`else
  assign div0_hit = 1'b0;
`endif

  // acc holds the upper product half (multiply) or the partial remainder (divide)
  assign mul_sum   = lower[0] ? acc + {1'b0, opb} : acc;
  assign div_shift = {acc[WIDTH-1:0], lower[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign prod      = {acc[WIDTH-1:0], lower};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = div0_hit ? S_FIX : S_CALC;
      S_CALC: if (cnt == CW'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: begin
        if (start) state_d = div0_hit ? S_FIX : S_CALC;
        else       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkACC or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
`ifdef MDU_DIV0_EN
      zdiv    <= 1'b0;
      div0    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept)                 cnt <= '0;
      else if (state_q == S_CALC) cnt <= cnt + CW'(1);
`ifdef MDU_DIV0_EN
      if (accept) begin
        zdiv <= div0_hit;
        div0 <= 1'b0;
      end
`endif
      // result write-back happens only in FIX, so HI/LO never show partial results
      if (state_q == S_FIX) begin
`ifdef MDU_DIV0_EN
        if (zdiv) begin
          hi   <= lower;
          lo   <= '1;
          div0 <= 1'b1;
        end else
`endif
        if (op_div) begin
          lo <= apply_sign(lower, q_neg);
          hi <= apply_sign(acc[WIDTH-1:0], r_neg);
        end else begin
          {hi, lo} <= apply_sign2(prod, q_neg);
        end
      end
    end
  end

  // operand capture at the start edge, then one shift-add / restoring step per CALC cycle
  always_ff @(posedge clkACC) begin
    if (accept) begin
      op_div <= op[1];
      q_neg  <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]) & (|B);
      r_neg  <= is_signed & A[WIDTH-1];
      acc    <= '0;
      lower  <= magnitude(A, is_signed);
      opb    <= magnitude(B, is_signed);
`ifdef MDU_DIV0_EN
      if (div0_hit) lower <= A;
`endif
    end else if (state_q == S_CALC) begin
      if (op_div) begin
        if (!div_diff[WIDTH]) begin
          acc   <= div_diff;
          lower <= {lower[WIDTH-2:0], 1'b1};
        end else begin
          acc   <= div_shift;
          lower <= {lower[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc   <= {1'b0, mul_sum[WIDTH:1]};
        lower <= {mul_sum[0], lower[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed cases plus randomized ops against an arithmetic reference model.
// Builds with or without MDU_DIV0_EN.
module tb_mul_div_unit;

  logic        clkACC = 1'b0;
  logic        reset  = 1'b1;
  logic        start  = 1'b0;
  logic [1:0]  op     = 2'd0;
  logic [31:0] A      = '0;
  logic [31:0] B      = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MDU_DIV0_EN
  logic        div0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clkACC = ~clkACC;

  mul_div_unit #(.WIDTH(32)) dut (
    .clkACC(clkACC),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
`ifdef MDU_DIV0_EN
    ,
    .div0  (div0)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {hi, lo} computed with plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] up;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin
        p = sa * sb;
        return p;
      end
      2'd1: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
        end else begin
          q = a / b;
          r = a % b;
        end
        return {r, q};
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge one cycle after the start edge
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clkACC);
    start = 1'b0;
    op    = 2'($urandom);
    A     = $urandom;
    B     = $urandom;
  endtask

  task automatic wait_done(input int k0, output int k, output int busy_bad);
    k        = k0;
    busy_bad = 0;
    while (!done && k < 40) begin
      if (busy !== 1'b1) busy_bad++;
      @(negedge clkACC);
      k++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int          k, bb, lat;
    exp = model(o, a, b);
    lat = 34;
`ifdef MDU_DIV0_EN
    if (o[1] && b == 32'd0) lat = 2;
`endif
    issue(o, a, b);
    wait_done(1, k, bb);
    check({tag, "_lat"}, 64'(k), 64'(lat));
    check({tag, "_busy"}, 64'(bb), 64'd0);
    check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    check({tag, "_hilo"}, {hi, lo}, exp);
`ifdef MDU_DIV0_EN
    check({tag, "_div0"}, 64'(div0), 64'(o[1] && b == 32'd0));
`endif
    @(negedge clkACC);
    check({tag, "_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, {hi, lo}, exp);
  endtask

  initial begin
    int k, bb, dones;

    #3 reset = 1'b0;
    #9;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
`ifdef MDU_DIV0_EN
    check("rst_div0", 64'(div0), 64'd0);
`endif
    @(negedge clkACC);
    reset = 1'b1;
    @(negedge clkACC);

    run_op("mult_neg",    2'd0, 32'hFFFF_FFFD, 32'd7);
    run_op("multu_max",   2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_neg",     2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op("divu",        2'd3, 32'd100,       32'd7);
    run_op("div_ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_zero",   2'd3, 32'd5,         32'd0);
    run_op("div_negzero", 2'd2, 32'hFFFF_FFFB, 32'd0);
    run_op("multu_big",   2'd1, 32'h8000_0000, 32'd2);

    // start while busy is ignored; start in the DONE cycle is accepted
    issue(2'd3, 32'd100, 32'd7);
    repeat (9) @(negedge clkACC);
    start = 1'b1; op = 2'd1; A = 32'd3; B = 32'd3;
    @(negedge clkACC);
    start = 1'b0;
    wait_done(11, k, bb);
    check("busy_ign_lat", 64'(k), 64'd34);
    check("busy_ign_hilo", {hi, lo}, {32'd2, 32'd14});
    issue(2'd1, 32'd3, 32'd3);
    check("b2b_done_low", 64'(done), 64'd0);
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done(1, k, bb);
    check("b2b_lat", 64'(k), 64'd34);
    check("b2b_hilo", {hi, lo}, {32'd0, 32'd9});
    @(negedge clkACC);

    // asynchronous reset mid-operation
    issue(2'd2, 32'd100, 32'd7);
    repeat (14) @(negedge clkACC);
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    @(negedge clkACC);
    reset = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clkACC);
      if (done) dones++;
    end
    check("midrst_no_done", 64'(dones), 64'd0);
    run_op("after_rst", 2'd2, 32'd100, 32'd7);

    for (int i = 0; i < 30; i++) begin
      run_op("rnd", 2'($urandom_range(0, 3)), rand_operand(), rand_operand());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
